// File: rtl/alu_accum_ctrl.sv
// Accumulator controller driving an external 8b combinational ALU.
// Each command walks through IDLE -> CALC -> RESP. The ALU operands are registered.
module alu_accum_ctrl #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [1:0]         req_cmd,
  input  logic [2:0]         req_op,
  input  logic [p_nbits-1:0] req_src,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic [1:0]         resp_cmd,
  output logic [p_nbits-1:0] resp_data,
  output logic [p_nbits-1:0] alu_in0,
  output logic [p_nbits-1:0] alu_in1,
  output logic [2:0]         alu_op,
  input  logic [p_nbits-1:0] alu_out
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

  localparam logic [1:0] C_LOAD  = 2'd0;
  localparam logic [1:0] C_EXEC  = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;
  localparam logic [1:0] C_CLEAR = 2'd3;

  state_t             r_state;
  logic [p_nbits-1:0] r_acc;
  logic [p_nbits-1:0] r_src;
  logic [2:0]         r_op;
  logic [1:0]         r_cmd;
  logic [p_nbits-1:0] r_resp_data;
  logic               r_resp_val;
  logic               r_req_rdy;
  logic [p_nbits-1:0] w_acc_nxt;

  always_comb begin
    w_acc_nxt = r_acc;
    case (r_cmd)
      C_LOAD:  w_acc_nxt = r_src;
      C_EXEC:  w_acc_nxt = alu_out;
      C_READ:  w_acc_nxt = r_acc;
      C_CLEAR: w_acc_nxt = '0;
      default: w_acc_nxt = r_acc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_src       <= '0;
      r_op        <= '0;
      r_cmd       <= '0;
      r_resp_data <= '0;
      r_resp_val  <= 1'b0;
      r_req_rdy   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_val && r_req_rdy) begin
            r_cmd     <= req_cmd;
            r_op      <= req_op;
            r_src     <= req_src;
            r_req_rdy <= 1'b0;
            r_state   <= S_CALC;
          end
        end
        // The ALU sees the registered operands during this cycle, so its result is ready at this edge.
        S_CALC: begin
          r_acc       <= w_acc_nxt;
          r_resp_data <= w_acc_nxt;
          r_resp_val  <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_rdy) begin
            r_resp_val <= 1'b0;
            r_req_rdy  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: begin
          r_resp_val <= 1'b0;
          r_req_rdy  <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign req_rdy   = r_req_rdy;
  assign resp_val  = r_resp_val;
  assign resp_cmd  = r_cmd;
  assign resp_data = r_resp_data;
  assign alu_in0   = r_acc;
  assign alu_in1   = r_src;
  assign alu_op    = r_op;

endmodule
